// File: rtl/led_pio_sequencer.sv
// Arbitrates CPU DIRECT writes and a table-driven pattern engine onto the LED PIO write port.
// Define LED_SEQ_ONESHOT_EN to enable the one-shot (CTRL bit1) mode.
module led_pio_sequencer #(
   parameter int WIDTH    = 10,
   parameter int DEPTH    = 8,
   parameter int PERIOD_W = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  pio_address,
   output logic        pio_chipselect,
   output logic        pio_write_n,
   output logic [31:0] pio_writedata
);

   typedef enum logic {S_IDLE, S_RUN} state_t;
   localparam logic [2:0] IDX_MASK = 3'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [2:0]          idx_q, idx_d, last_q, last_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d, period_m1;
   logic                tick_q, tick_d;
   logic                oneshot_q, oneshot_d;
   logic                dir_req_q, dir_req_d;
   logic [WIDTH-1:0]    dir_data_q, dir_data_d;
   logic                eng_req_q, eng_req_d;
   logic [WIDTH-1:0]    eng_data_q, eng_data_d;
   logic                pio_cs_q, pio_cs_d;
   logic [WIDTH-1:0]    pio_data_q, pio_data_d;
   logic [WIDTH-1:0]    shadow_q, shadow_d;
   logic [WIDTH-1:0]    tbl_q [8];

   logic wr, wr_ctrl, wr_period, wr_tbl, wr_dir, start, stop, eng_last;
   logic unused_wdata;

   assign wr        = s_chipselect & ~s_write_n;
   assign wr_ctrl   = wr && (s_address == 2'd0);
   assign wr_period = wr && (s_address == 2'd1);
   assign wr_tbl    = wr && (s_address == 2'd2);
   assign wr_dir    = wr && (s_address == 2'd3);
   assign start     = wr_ctrl && s_writedata[0] && (state_q == S_IDLE);
   assign stop      = wr_ctrl && !s_writedata[0];
   assign period_m1 = (period_q == '0) ? '0 : period_q - 1'b1;
   assign eng_last  = oneshot_q && (idx_q == last_q);
   assign unused_wdata = ^s_writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         last_q     <= 3'd7;
         cnt_q      <= '0;
         period_q   <= '0;
         tick_q     <= 1'b0;
         oneshot_q  <= 1'b0;
         dir_req_q  <= 1'b0;
         dir_data_q <= '0;
         eng_req_q  <= 1'b0;
         eng_data_q <= '0;
         pio_cs_q   <= 1'b0;
         pio_data_q <= '0;
         shadow_q   <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         tick_q     <= tick_d;
         oneshot_q  <= oneshot_d;
         dir_req_q  <= dir_req_d;
         dir_data_q <= dir_data_d;
         eng_req_q  <= eng_req_d;
         eng_data_q <= eng_data_d;
         pio_cs_q   <= pio_cs_d;
         pio_data_q <= pio_data_d;
         shadow_q   <= shadow_d;
      end
   end

   // Table has no reset; contents are undefined until software loads them.
   always_ff @(posedge clk) begin
      if (wr_tbl) tbl_q[s_writedata[12:10] & IDX_MASK] <= s_writedata[WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               idx_d   = '0;
               cnt_d   = '0;
               tick_d  = 1'b1;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else begin
               if (cnt_q >= period_m1) begin
                  cnt_d  = '0;
                  tick_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (tick_q) begin
                  idx_d = (idx_q >= last_q) ? 3'd0 : idx_q + 3'd1;
                  if (eng_last) begin
                     state_d = S_IDLE;
                     idx_d   = '0;
                     cnt_d   = '0;
                     tick_d  = 1'b0;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Both writers post into request registers; the engine request doubles as the pending slot.
   always_comb begin
      last_d     = wr_ctrl ? s_writedata[6:4] : last_q;
      period_d   = wr_period ? s_writedata[PERIOD_W-1:0] : period_q;
`ifdef LED_SEQ_ONESHOT_EN
      oneshot_d  = wr_ctrl ? s_writedata[1] : oneshot_q;
`else
      oneshot_d  = 1'b0;
`endif
      dir_req_d  = wr_dir;
      dir_data_d = wr_dir ? s_writedata[WIDTH-1:0] : dir_data_q;
      eng_req_d  = eng_req_q;
      eng_data_d = eng_data_q;
      pio_cs_d   = 1'b0;
      pio_data_d = pio_data_q;
      if (dir_req_q) begin
         pio_cs_d   = 1'b1;
         pio_data_d = dir_data_q;
      end else if (eng_req_q && !stop) begin
         pio_cs_d   = 1'b1;
         pio_data_d = eng_data_q;
         eng_req_d  = 1'b0;
      end
      if (stop) begin
         eng_req_d = 1'b0;
      end else if (tick_q) begin
         eng_req_d  = 1'b1;
         eng_data_d = tbl_q[idx_q & IDX_MASK];
      end
      shadow_d = pio_cs_d ? pio_data_d : shadow_q;
   end

   always_comb begin
      pio_address                = '0;
      pio_chipselect             = pio_cs_q;
      pio_write_n                = ~pio_cs_q;
      pio_writedata              = '0;
      pio_writedata[WIDTH-1:0]   = pio_data_q;
      s_readdata                 = '0;
      unique case (s_address)
         2'd0: begin
            s_readdata[0]     = (state_q == S_RUN);
            s_readdata[1]     = oneshot_q;
            s_readdata[6:4]   = last_q;
            s_readdata[18:16] = idx_q;
         end
         2'd1: s_readdata[PERIOD_W-1:0] = period_q;
         2'd3: s_readdata[WIDTH-1:0]    = shadow_q;
         default: ;
      endcase
   end

endmodule

// File: doc/led_pio_sequencer.md
# led_pio_sequencer

Avalon-MM controller between the CPU data master and the 10-bit LED PIO output slave. It arbitrates two writers of the PIO data register onto the PIO's single write port:
- direct CPU writes;
- a hardware pattern engine that steps through a programmable table at a programmable period.

It also keeps a shadow of the last value driven, so software can read back what the LEDs show.

## Interface
Parameters:
- WIDTH, 10, LED data width; must match the PIO width.
- DEPTH, 8, pattern table entries; must be a power of two, at most 8.
- PERIOD_W, 24, width of the step-period counter.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- s_address  in  2  CSR word address.
- s_chipselect  in  1  CSR select.
- s_write_n  in  1  CSR write strobe, active low.
- s_writedata  in  32  CSR write data.
- s_readdata  out  32  CSR read data, combinational, zero wait states.
- pio_address  out  2  to PIO s1; always 0.
- pio_chipselect  out  1  to PIO s1.
- pio_write_n  out  1  to PIO s1, active low.
- pio_writedata  out  32  to PIO s1; bits [WIDTH-1:0] carry data, upper bits 0.

## Operation
CSR map; a write takes effect on the edge where chipselect=1 and write_n=0:
- Address 0, CTRL:
  - bit0 RUN.
  - bit1 ONESHOT.
  - bits[6:4] LAST, the final table index.
  - Read adds bits[18:16] IDX, the current index.
- Address 1, PERIOD: bits[PERIOD_W-1:0]. A value of 0 is treated as 1.
- Address 2, TABLE write: writes bits[9:0] into entry bits[12:10], with the index masked to DEPTH. Reads return 0.
- Address 3, DIRECT:
  - Write issues bits[9:0] to the PIO.
  - Read returns SHADOW, the last value issued to the PIO.

Pattern engine, states IDLE and RUN:
- IDLE to RUN when a CTRL write sets RUN=1 while RUN=0. This clears IDX and the period counter and raises a tick on the next cycle, so table[0] is issued immediately.
- In RUN, the counter increments every cycle. When it reaches PERIOD-1 it clears and raises a tick.
- Each tick requests a write of table[IDX]. IDX then advances, wrapping from LAST to 0.
- RUN to IDLE on a CTRL write with RUN=0. This clears IDX, the counter and any pending engine request. An already-issued PIO write is not retracted.
- A PERIOD or LAST change while in RUN applies from the next comparison. IDX greater than LAST wraps to 0 on its next advance.

Arbitration, fixed priority:
- A DIRECT write always wins the PIO port.
- An engine request that collides with a DIRECT write is held in a one-entry pending register and issued on the first free cycle.
- A newer tick overwrites a held pending request, so the latest value wins. The period counter never stalls.

Each PIO write is a single-cycle pulse: pio_chipselect=1, pio_write_n=0, pio_address=0. SHADOW updates on the same edge that launches the pulse.

## Timing
- Reset values:
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
  - SHADOW=0, RUN=0, ONESHOT=0, LAST=7, PERIOD=0, IDX=0, pending=0.
  - Table contents are undefined after reset.
- DIRECT write at edge N: PIO pulse is high during cycle N+1, and the PIO latches on edge N+2.
- RUN set at edge N: table[0] pulse is high during cycle N+2. Subsequent pulses come every PERIOD cycles.
- A deferred engine write is delayed exactly one cycle per consecutive DIRECT write.
- s_readdata is combinational from registered state. There is no read side effect.
- Reset mid-pulse: the outputs return to their idle values on the reset edge.

## Configuration
- LED_SEQ_ONESHOT_EN defined:
  - With ONESHOT=1, the engine clears RUN and returns to IDLE in the cycle after issuing the table[LAST] request.
  - CTRL bit1 is readable and writable.
- LED_SEQ_ONESHOT_EN undefined:
  - The engine always loops.
  - CTRL bit1 is ignored on write and reads 0.

## Test plan
- Reset, then read all CSRs: CTRL=0x70, PERIOD=0, DIRECT readback=0; pio_write_n=1 throughout.
- DIRECT write 0x2A5: exactly one PIO pulse with writedata=0x2A5 two edges later; DIRECT readback=0x2A5.
- Table = 0x001,0x002,0x004,0x008; LAST=3; PERIOD=5; set RUN: pulses carry 1,2,4,8,1,… spaced exactly 5 cycles apart, the first 2 cycles after the CTRL write.
- PERIOD=1 with RUN, plus a DIRECT write of 0x3FF coinciding with a tick: 0x3FF is issued first, then the engine value one cycle later; the next tick overwrites the pending value if it is still blocked.
- With LED_SEQ_ONESHOT_EN, ONESHOT=1, LAST=2: exactly 3 pulses (table[0..2]), then CTRL reads RUN=0. Without the macro: continuous looping and bit1 reads 0.
- Clear RUN during a pending collision: no engine pulse follows; IDX reads 0.
